// File: rtl/smg_pkg.sv
// Shared constants for the two-digit seven-segment scanner: segment
// patterns (common anode, active-low), digit-select codes and FSM states.
package smg_pkg;

    // Segment patterns for digits 0-9, bit order {dp,g,f,e,d,c,b,a}, active-low
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low digit selects: bit0 drives the tens digit, bit1 the ones digit
    localparam logic [1:0] SCAN_OFF = 2'b11;
    localparam logic [1:0] SCAN_TEN = 2'b10;
    localparam logic [1:0] SCAN_ONE = 2'b01;

    // Scanner FSM states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BLANK_TEN = 3'd1,
        SHOW_TEN  = 3'd2,
        BLANK_ONE = 3'd3,
        SHOW_ONE  = 3'd4
    } smg_state_e;

    // Map a decimal digit to its segment pattern; anything above 9 is blank
    function automatic logic [7:0] seg_of_digit(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/smg_slot_timer.sv
// Slot counter for the scanner: counts 0..SCAN_DIV-1 inside one digit slot
// and flags the last blanked cycle and the last cycle of the slot.
module smg_slot_timer #(
    parameter  int SCAN_DIV  = 50000,
    parameter  int BLANK_CYC = 500,
    localparam int CNT_W     = $clog2(SCAN_DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             blank_end_o,
    output logic             slot_end_o
);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    // With no blanking there is no blank_end; the value below is then unused
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign slot_end_o  = (cnt_q == SLOT_LAST);
    assign blank_end_o = (BLANK_CYC > 0) && (cnt_q == BLANK_LAST);
    assign cnt_o       = cnt_q;

    // Next count: clear wins, otherwise wrap at the end of the slot
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = slot_end_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/smg_scan_mod.sv
// Two-digit multiplexed seven-segment scanner. A frame is a tens slot then
// a ones slot, each SCAN_DIV cycles long, each opening with BLANK_CYC cycles
// of all-off to stop the previous digit ghosting onto the next.
// Segment inputs are snapshotted at frame start, so a frame always shows a
// consistent pair and input changes appear only from the next frame.
//
// en is a level: sampled in IDLE to start, and at the last cycle of a frame
// to decide between restarting and returning to IDLE. Dropping it mid-frame
// never truncates the frame.
module smg_scan_mod
    import smg_pkg::*;
#(
    parameter  int SCAN_DIV  = 50000,
    parameter  int BLANK_CYC = 500,
    localparam int CNT_W     = $clog2(SCAN_DIV)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [7:0]       ten_encode,
    input  logic [7:0]       one_encode,
    output logic [1:0]       Scan_Sig,
    output logic [7:0]       SMG_Data,
    output logic             frame_tick,
    output smg_state_e       dbg_state_o,
    output logic [CNT_W-1:0] dbg_cnt_o
);

    // Reject parameter sets that would make a slot shorter than its blanking
    if (SCAN_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_param
        $error("smg_scan_mod: need SCAN_DIV>=2 and 0<=BLANK_CYC<SCAN_DIV");
    end

    // First state of a frame: the blank slot is skipped when there is no blanking
    localparam smg_state_e FIRST_TEN = (BLANK_CYC == 0) ? SHOW_TEN : BLANK_TEN;
    localparam smg_state_e FIRST_ONE = (BLANK_CYC == 0) ? SHOW_ONE : BLANK_ONE;

    smg_state_e       state_q;
    smg_state_e       state_d;
    logic [7:0]       ten_snap_q;
    logic [7:0]       ten_snap_d;
    logic [7:0]       one_snap_q;
    logic [7:0]       one_snap_d;
    logic [1:0]       scan_q;
    logic [1:0]       scan_d;
    logic [7:0]       data_q;
    logic [7:0]       data_d;
    logic             tick_q;
    logic             tick_d;
    logic             start_frame;
    logic [CNT_W-1:0] slot_cnt;
    logic             blank_end;
    logic             slot_end;

    // The counter idles at zero, so every frame starts from cnt=0
    smg_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .clk_i       (CLK),
        .rst_i       (RST),
        .clear_i     (state_q == IDLE),
        .enable_i    (state_q != IDLE),
        .cnt_o       (slot_cnt),
        .blank_end_o (blank_end),
        .slot_end_o  (slot_end)
    );

    // Next state, snapshots and registered output values
    always_comb begin
        state_d     = state_q;
        ten_snap_d  = ten_snap_q;
        one_snap_d  = one_snap_q;
        tick_d      = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    start_frame = 1'b1;
                end
            end
            BLANK_TEN: begin
                if (blank_end) begin
                    state_d = SHOW_TEN;
                end
            end
            SHOW_TEN: begin
                if (slot_end) begin
                    state_d = FIRST_ONE;
                end
            end
            BLANK_ONE: begin
                if (blank_end) begin
                    state_d = SHOW_ONE;
                end
            end
            SHOW_ONE: begin
                if (slot_end) begin
                    if (en) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_frame) begin
            state_d    = FIRST_TEN;
            ten_snap_d = ten_encode;
            one_snap_d = one_encode;
            tick_d     = 1'b1;
        end

        // Outputs follow the next state so they register together with it
        scan_d = SCAN_OFF;
        data_d = SEG_BLANK;
        case (state_d)
            SHOW_TEN: begin
                scan_d = SCAN_TEN;
                data_d = ten_snap_d;
            end
            SHOW_ONE: begin
                scan_d = SCAN_ONE;
                data_d = one_snap_d;
            end
            default: begin
                scan_d = SCAN_OFF;
                data_d = SEG_BLANK;
            end
        endcase
    end

    // FSM state, snapshots and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ten_snap_q <= SEG_BLANK;
            one_snap_q <= SEG_BLANK;
            scan_q     <= SCAN_OFF;
            data_q     <= SEG_BLANK;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ten_snap_q <= ten_snap_d;
            one_snap_q <= one_snap_d;
            scan_q     <= scan_d;
            data_q     <= data_d;
            tick_q     <= tick_d;
        end
    end

    assign Scan_Sig    = scan_q;
    assign SMG_Data    = data_q;
    assign frame_tick  = tick_q;
    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = slot_cnt;

    // Both digits must never be selected in the same cycle
    a_scan_exclusive : assert property (@(posedge CLK) disable iff (RST) Scan_Sig != 2'b00);

endmodule
